// File: rtl/eth_tx_scheduler.sv
// eth_tx_scheduler: two-requester arbiter feeding an Ethernet framer.
// Reads frame bytes from the granted requester's buffer and paces them
// to the framer on its byte_sent handshake.
//
// Ports:
//   tx_clock_i, tx_reset_i  clock, synchronous active-high reset
//   req_i[1:0]              per-requester frame-ready level
//   len0_i, len1_i          frame length in bytes (no FCS)
//   grant_o[1:0]            one-hot current owner
//   done_o[1:0], err_o      completion / rejection pulses
//   buf_sel_o, buf_addr_o,
//   buf_rd_o, buf_data_i    buffer read port (data 1 cycle after rd)
//   fr_tx_enable_o,
//   fr_tx_data_o            framer data inputs
//   fr_tx_byte_sent_i,
//   fr_tx_busy_i            framer status
//
// Build option: define TX_SCHED_STRICT_PRIO_EN for fixed priority
// (requester 0 wins ties); default is round-robin.

module eth_tx_scheduler (
    input  logic        tx_clock_i,
    input  logic        tx_reset_i,
    input  logic [1:0]  req_i,
    input  logic [10:0] len0_i,
    input  logic [10:0] len1_i,
    output logic [1:0]  grant_o,
    output logic [1:0]  done_o,
    output logic        err_o,
    output logic        buf_sel_o,
    output logic [10:0] buf_addr_o,
    output logic        buf_rd_o,
    input  logic [7:0]  buf_data_i,
    output logic        fr_tx_enable_o,
    output logic [7:0]  fr_tx_data_o,
    input  logic        fr_tx_byte_sent_i,
    input  logic        fr_tx_busy_i
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        PREFETCH,
        LOAD,
        START,
        STREAM,
        DRAIN
    } state_t;

    localparam logic [10:0] MAX_LEN = 11'd1514;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        win_q, win_d;
    logic [10:0] len_q, len_d;
    logic [10:0] cnt_q, cnt_d;
    logic        rr_q, rr_d;
    logic [1:0]  done_q, done_d;
    logic        err_q, err_d;
    logic        rd_q, rd_d;
    logic [10:0] addr_q, addr_d;
    logic        sel_q, sel_d;
    logic        en_q, en_d;
    logic [7:0]  data_q, data_d;
    logic        ld_q, ld_d;

    logic        pick;
    logic        len_bad;
    logic        last_byte;

`ifdef TX_SCHED_STRICT_PRIO_EN
    assign pick = ~req_i[0];
`else
    // rr_q names the requester preferred on a tie
    assign pick = (req_i == 2'b11) ? rr_q : req_i[1];
`endif

    assign len_bad   = (len_q == 11'd0) || (len_q > MAX_LEN);
    assign last_byte = (cnt_q == len_q - 11'd1);

    always_ff @(posedge tx_clock_i) begin
        if (tx_reset_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            win_q   <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
            rr_q    <= 1'b0;
            done_q  <= '0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            sel_q   <= 1'b0;
            en_q    <= 1'b0;
            data_q  <= '0;
            ld_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            win_q   <= win_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            data_q  <= data_d;
            ld_q    <= ld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (|req_i) state_d = CHECK;
            CHECK:    state_d = len_bad ? IDLE : PREFETCH;
            PREFETCH: state_d = LOAD;
            LOAD:     state_d = START;
            START:    if (fr_tx_busy_i) state_d = STREAM;
            STREAM: begin
                if (fr_tx_byte_sent_i && last_byte)
                    state_d = DRAIN;
            end
            DRAIN:    if (!fr_tx_busy_i) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Outputs are registered: each state computes the values that
    // become visible in the following cycle.
    always_comb begin
        grant_d = grant_q;
        win_d   = win_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        en_d    = en_q;
        data_d  = data_q;
        done_d  = '0;
        err_d   = 1'b0;
        rd_d    = 1'b0;
        ld_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req_i) begin
                    win_d   = pick;
                    grant_d = pick ? 2'b10 : 2'b01;
                    len_d   = pick ? len1_i : len0_i;
                end
            end
            CHECK: begin
                if (len_bad) begin
                    done_d  = grant_q;
                    err_d   = 1'b1;
                    grant_d = '0;
                    rr_d    = ~win_q;
                end else begin
                    // read strobe lands in PREFETCH, data in LOAD
                    cnt_d  = '0;
                    rd_d   = 1'b1;
                    addr_d = '0;
                    sel_d  = win_q;
                end
            end
            LOAD: begin
                data_d = buf_data_i;
                en_d   = 1'b1;
            end
            STREAM: begin
                // ld_q marks the cycle buf_data_i answers rd_q
                ld_d = rd_q;
                if (ld_q)
                    data_d = buf_data_i;
                if (fr_tx_byte_sent_i) begin
                    if (last_byte) begin
                        en_d = 1'b0;
                    end else begin
                        cnt_d  = cnt_q + 11'd1;
                        rd_d   = 1'b1;
                        addr_d = cnt_q + 11'd1;
                    end
                end
            end
            DRAIN: begin
                if (!fr_tx_busy_i) begin
                    done_d  = grant_q;
                    grant_d = '0;
                    rr_d    = ~win_q;
                end
            end
            default: ;
        endcase
    end

    assign grant_o        = grant_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign buf_sel_o      = sel_q;
    assign buf_addr_o     = addr_q;
    assign buf_rd_o       = rd_q;
    assign fr_tx_enable_o = en_q;
    assign fr_tx_data_o   = data_q;

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// tb_eth_tx_scheduler: directed bench with buffer and framer models.
// Framer model emits byte_sent every 4 cycles while enabled.

module tb_eth_tx_scheduler;

    logic        clk;
    logic        tx_reset_i;
    logic [1:0]  req_i;
    logic [10:0] len0_i, len1_i;
    logic [1:0]  grant_o, done_o;
    logic        err_o, buf_sel_o, buf_rd_o;
    logic [10:0] buf_addr_o;
    logic [7:0]  buf_data_i;
    logic        fr_tx_enable_o;
    logic [7:0]  fr_tx_data_o;
    logic        fr_tx_byte_sent_i, fr_tx_busy_i;

    eth_tx_scheduler dut (
        .tx_clock_i        (clk),
        .tx_reset_i        (tx_reset_i),
        .req_i             (req_i),
        .len0_i            (len0_i),
        .len1_i            (len1_i),
        .grant_o           (grant_o),
        .done_o            (done_o),
        .err_o             (err_o),
        .buf_sel_o         (buf_sel_o),
        .buf_addr_o        (buf_addr_o),
        .buf_rd_o          (buf_rd_o),
        .buf_data_i        (buf_data_i),
        .fr_tx_enable_o    (fr_tx_enable_o),
        .fr_tx_data_o      (fr_tx_data_o),
        .fr_tx_byte_sent_i (fr_tx_byte_sent_i),
        .fr_tx_busy_i      (fr_tx_busy_i)
    );

    localparam int SPACE = 4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem0 [0:2047];
    logic [7:0] mem1 [0:2047];

    // monitor state
    int   cyc = 0;
    int   rd_cnt, addr_err, sent_cnt, data_err, done_cnt;
    int   err_cnt, err_stray, onehot_err, en_seen;
    int   grant_cyc, done_cyc, busy_fall_cyc, en_fall_cyc;
    int   last_sent_cyc, last_addr, gwin, done_vec;
    logic prev_grant_nz, prev_en;

    // model state
    logic        prev_rd, prev_sel;
    logic [10:0] prev_addr;
    int          phase, spc, tail;

    function automatic logic [7:0] memrd(input logic s, input logic [10:0] a);
        return s ? mem1[a] : mem0[a];
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clr_mon();
        rd_cnt = 0; addr_err = 0; sent_cnt = 0; data_err = 0;
        done_cnt = 0; err_cnt = 0; en_seen = 0;
        grant_cyc = -1; done_cyc = -1; busy_fall_cyc = -1;
        en_fall_cyc = -1; last_sent_cyc = -1; last_addr = -1;
        done_vec = 0;
    endtask

    // Buffer, framer model and monitor, all at the falling edge.
    initial begin
        fr_tx_byte_sent_i = 1'b0;
        fr_tx_busy_i = 1'b0;
        buf_data_i = 8'hA5;
        prev_rd = 1'b0; prev_sel = 1'b0; prev_addr = '0;
        phase = 0; spc = 0; tail = 0;
        prev_grant_nz = 1'b0; prev_en = 1'b0;
        err_stray = 0; onehot_err = 0; gwin = 0;
        clr_mon();
        forever begin
            @(negedge clk);
            cyc++;
            if (grant_o == 2'b11) onehot_err++;
            if (grant_o != 0 && !prev_grant_nz) begin
                grant_cyc = cyc;
                gwin = int'(grant_o[1]);
            end
            prev_grant_nz = (grant_o != 0);
            if (buf_rd_o) begin
                if (buf_addr_o != 11'(rd_cnt) || int'(buf_sel_o) != gwin)
                    addr_err++;
                last_addr = int'(buf_addr_o);
                rd_cnt++;
            end
            if (done_o != 0) begin
                done_cnt++;
                done_cyc = cyc;
                done_vec = int'(done_o);
                if (err_o) err_cnt++;
            end else if (err_o) begin
                err_stray++;
            end
            if (fr_tx_enable_o) en_seen = 1;
            if (prev_en && !fr_tx_enable_o) en_fall_cyc = cyc;
            prev_en = fr_tx_enable_o;

            buf_data_i = prev_rd ? memrd(prev_sel, prev_addr) : 8'hA5;
            prev_rd = buf_rd_o && !tx_reset_i;
            prev_sel = buf_sel_o;
            prev_addr = buf_addr_o;

            fr_tx_byte_sent_i = 1'b0;
            if (tx_reset_i) begin
                fr_tx_busy_i = 1'b0;
                phase = 0;
            end else begin
                case (phase)
                    0: if (fr_tx_enable_o) begin
                        fr_tx_busy_i = 1'b1;
                        phase = 1;
                        spc = 0;
                    end
                    1: begin
                        spc++;
                        if (spc == SPACE) begin
                            spc = 0;
                            if (fr_tx_enable_o) begin
                                fr_tx_byte_sent_i = 1'b1;
                                if (fr_tx_data_o !=
                                    memrd(gwin[0], 11'(sent_cnt)))
                                    data_err++;
                                sent_cnt++;
                                last_sent_cyc = cyc;
                            end else begin
                                phase = 2;
                                tail = 5;
                            end
                        end
                    end
                    default: begin
                        if (tail == 0) begin
                            fr_tx_busy_i = 1'b0;
                            busy_fall_cyc = cyc;
                            phase = 0;
                        end else begin
                            tail--;
                        end
                    end
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tx_reset_i = 1'b1;
        repeat (3) tick();
        tx_reset_i = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [1:0] req,
                             input logic [10:0] l0, input logic [10:0] l1,
                             input int ew, input bit eerr);
        int n;
        int len;
        clr_mon();
        len0_i = l0;
        len1_i = l1;
        req_i = req;
        n = 0;
        while (grant_o == 0 && n < 50) begin
            tick();
            n++;
        end
        req_i = 2'b00;
        chk({tag, "_grant_timeout"}, int'(n >= 50), 0);
        n = 0;
        while (done_cnt == 0 && n < 20000) begin
            tick();
            n++;
        end
        chk({tag, "_done_timeout"}, int'(n >= 20000), 0);
        repeat (8) tick();
        len = ew ? int'(l1) : int'(l0);
        chk({tag, "_winner"}, gwin, ew);
        chk({tag, "_done_vec"}, done_vec, ew ? 2 : 1);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_err_cnt"}, err_cnt, eerr ? 1 : 0);
        chk({tag, "_rd_cnt"}, rd_cnt, eerr ? 0 : len);
        chk({tag, "_sent_cnt"}, sent_cnt, eerr ? 0 : len);
        if (eerr) begin
            chk({tag, "_en_seen"}, en_seen, 0);
            chk({tag, "_done_lat"}, done_cyc - grant_cyc, 1);
        end else begin
            chk({tag, "_addr_err"}, addr_err, 0);
            chk({tag, "_data_err"}, data_err, 0);
            chk({tag, "_last_addr"}, last_addr, len - 1);
            chk({tag, "_en_fall"}, en_fall_cyc - last_sent_cyc, 1);
            chk({tag, "_done_after_busy"}, done_cyc - busy_fall_cyc, 1);
        end
    endtask

    typedef struct {
        string       tag;
        bit          rst;
        logic [1:0]  req;
        logic [10:0] l0;
        logic [10:0] l1;
        int          win;
        bit          err;
    } vec_t;

    vec_t tab [9];

    initial begin
        int n;
        int rr_w;
`ifdef TX_SCHED_STRICT_PRIO_EN
        rr_w = 0;
`else
        rr_w = 1;
`endif
        tab[0] = '{"single60",  1, 2'b01, 11'd60,  11'd0,    0, 0};
        tab[1] = '{"both_a",    1, 2'b11, 11'd64,  11'd64,   0, 0};
        tab[2] = '{"both_b",    0, 2'b11, 11'd64,  11'd64,   rr_w, 0};
        tab[3] = '{"both_c",    0, 2'b11, 11'd64,  11'd64,   0, 0};
        tab[4] = '{"len_zero",  0, 2'b10, 11'd60,  11'd0,    1, 1};
        tab[5] = '{"len_1515",  0, 2'b10, 11'd60,  11'd1515, 1, 1};
        tab[6] = '{"srcsub64",  0, 2'b01, 11'd64,  11'd0,    0, 0};
        tab[7] = '{"len_1514",  0, 2'b10, 11'd0,   11'd1514, 1, 0};
        tab[8] = '{"len_one",   0, 2'b01, 11'd1,   11'd0,    0, 0};

        for (int i = 0; i < 2048; i++) begin
            mem0[i] = 8'((i * 7 + 1) & 255);
            mem1[i] = 8'((i * 11 + 13) & 255);
        end
        mem0[6] = 8'hFF;
        mem1[6] = 8'hFF;

        req_i = 2'b00;
        len0_i = '0;
        len1_i = '0;
        tx_reset_i = 1'b1;
        repeat (3) tick();
        chk("rst_grant", int'(grant_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_err", int'(err_o), 0);
        chk("rst_rd", int'(buf_rd_o), 0);
        chk("rst_addr", int'(buf_addr_o), 0);
        chk("rst_sel", int'(buf_sel_o), 0);
        chk("rst_en", int'(fr_tx_enable_o), 0);
        chk("rst_data", int'(fr_tx_data_o), 0);
        tx_reset_i = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            if (tab[i].rst) do_reset();
            run_frame(tab[i].tag, tab[i].req, tab[i].l0, tab[i].l1,
                      tab[i].win, tab[i].err);
        end

        // reset after 20 bytes of a frame
        clr_mon();
        len0_i = 11'd64;
        req_i = 2'b01;
        n = 0;
        while (grant_o == 0 && n < 50) begin
            tick();
            n++;
        end
        req_i = 2'b00;
        n = 0;
        while (sent_cnt < 20 && n < 2000) begin
            tick();
            n++;
        end
        chk("midrst_reach20", int'(n >= 2000), 0);
        tx_reset_i = 1'b1;
        tick();
        chk("midrst_grant", int'(grant_o), 0);
        chk("midrst_en", int'(fr_tx_enable_o), 0);
        chk("midrst_rd", int'(buf_rd_o), 0);
        chk("midrst_addr", int'(buf_addr_o), 0);
        chk("midrst_sel", int'(buf_sel_o), 0);
        chk("midrst_data", int'(fr_tx_data_o), 0);
        chk("midrst_err", int'(err_o), 0);
        repeat (3) tick();
        tx_reset_i = 1'b0;
        repeat (10) tick();
        chk("midrst_no_done", done_cnt, 0);
        run_frame("after_rst", 2'b10, 11'd0, 11'd60, 1, 0);

        chk("grant_onehot", onehot_err, 0);
        chk("err_without_done", err_stray, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
